// File: rtl/pwm_pkg.sv
// Shared types and constants for the PWM generator slice.
// Contents:
//   pwm_state_e   - controller state (IDLE / RUN / STOP)
//   MinSyncStages - smallest synchroniser depth that is metastability-safe
package pwm_pkg;

  typedef enum logic [1:0] {
    StIdle = 2'd0,
    StRun  = 2'd1,
    StStop = 2'd2
  } pwm_state_e;

  localparam int unsigned MinSyncStages = 2;

endpackage

// File: rtl/edge_sync.sv
// Synchroniser plus rising-edge detector for a slow, asynchronous tick source
// (typically a divided clock treated as data).
// Ports:
//   clk_in  - sampling clock
//   rst_n   - asynchronous active-low reset
//   async_i - asynchronous level input
//   tick_o  - one-cycle pulse per rising edge of async_i (combinational from flops)
module edge_sync
  import pwm_pkg::*;
#(
  parameter int unsigned SyncStages = MinSyncStages
) (
  input  logic clk_in,
  input  logic rst_n,
  input  logic async_i,
  output logic tick_o
);

  // A shallower chain is never allowed; clamp rather than build an unsafe one.
  localparam int unsigned Stages = (SyncStages < MinSyncStages) ? MinSyncStages : SyncStages;

  logic [Stages-1:0] sync_q, sync_d;
  logic              edge_q, edge_d;

  always_comb begin
    sync_d = {sync_q[Stages-2:0], async_i};
    edge_d = sync_q[Stages-1];
  end

  always_ff @(posedge clk_in or negedge rst_n) begin
    if (!rst_n) begin
      sync_q <= '0;
      edge_q <= 1'b0;
    end else begin
      sync_q <= sync_d;
      edge_q <= edge_d;
    end
  end

  // A long high phase only produces one tick: edge_q follows the last stage.
  assign tick_o = sync_q[Stages-1] & ~edge_q;

endmodule

// File: rtl/pwm_generator.sv
// Programmable PWM generator clocked by ticks derived from a divided clock.
// Period and duty (in ticks) are taken through a valid/ready handshake; while
// running they are double-buffered and applied only at a period wrap.
// Optional feature macro: PWM_COMPL_EN adds a registered complementary output pwm_n.
// Ports:
//   clk_in, rst_n          - system clock, asynchronous active-low reset
//   tick_src               - divided clock (asynchronous)
//   enable                 - run request
//   cfg_valid / cfg_ready  - configuration handshake
//   cfg_period, cfg_duty   - period and high time in ticks
//   pwm_out                - registered PWM waveform
//   pwm_n                  - (PWM_COMPL_EN) ~pwm_out while running, 0 in IDLE
//   period_done            - one-cycle pulse at each period wrap
//   busy                   - state is not IDLE
module pwm_generator
  import pwm_pkg::*;
#(
  parameter int unsigned WIDTH       = 8,
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic             clk_in,
  input  logic             rst_n,
  input  logic             tick_src,
  input  logic             enable,
  input  logic             cfg_valid,
  output logic             cfg_ready,
  input  logic [WIDTH-1:0] cfg_period,
  input  logic [WIDTH-1:0] cfg_duty,
  output logic             pwm_out,
`ifdef PWM_COMPL_EN
  output logic             pwm_n,
`endif
  output logic             period_done,
  output logic             busy
);

  logic tick;

  edge_sync #(
    .SyncStages(SYNC_STAGES)
  ) u_edge_sync (
    .clk_in (clk_in),
    .rst_n  (rst_n),
    .async_i(tick_src),
    .tick_o (tick)
  );

  pwm_state_e       state_q, state_d;
  logic [WIDTH-1:0] cnt_q, cnt_d;
  logic [WIDTH-1:0] act_period_q, act_period_d;
  logic [WIDTH-1:0] act_duty_q, act_duty_d;
  logic [WIDTH-1:0] shd_period_q, shd_period_d;
  logic [WIDTH-1:0] shd_duty_q, shd_duty_d;
  logic             pending_q, pending_d;
  logic             pwm_q, pwm_d;
  logic             done_q, done_d;
`ifdef PWM_COMPL_EN
  logic             pwm_n_q, pwm_n_d;
`endif

  logic             cfg_hs;
  logic             wrap;
  logic [WIDTH-1:0] last_cnt;
  logic [WIDTH-1:0] cnt_inc;
  logic [WIDTH-1:0] wrap_duty;

  // Period 0 behaves as period 1, so the last count is 0 in both cases.
  assign last_cnt  = (act_period_q == '0) ? '0 : act_period_q - 1'b1;
  assign cnt_inc   = cnt_q + 1'b1;
  assign wrap      = (cnt_q == last_cnt);
  assign wrap_duty = pending_q ? shd_duty_q : act_duty_q;
  assign cfg_hs    = cfg_valid & cfg_ready;

  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    act_period_d = act_period_q;
    act_duty_d   = act_duty_q;
    shd_period_d = shd_period_q;
    shd_duty_d   = shd_duty_q;
    pending_d    = pending_q;
    pwm_d        = pwm_q;
    done_d       = 1'b0;

    unique case (state_q)
      StIdle: begin
        cnt_d = '0;
        pwm_d = 1'b0;
        if (cfg_hs) begin
          act_period_d = cfg_period;
          act_duty_d   = cfg_duty;
        end
        if (tick && enable) begin
          state_d = StRun;
          pwm_d   = (act_duty_q != '0);
        end
      end
      StRun, StStop: begin
        if (state_q == StRun && !enable) begin
          state_d = StStop;
        end else if (state_q == StStop && enable) begin
          state_d = StRun;
        end
        if (tick) begin
          if (wrap) begin
            cnt_d  = '0;
            done_d = 1'b1;
            pwm_d  = (wrap_duty != '0);
            if (pending_q) begin
              act_period_d = shd_period_q;
              act_duty_d   = shd_duty_q;
              pending_d    = 1'b0;
            end
            if (state_q == StStop && !enable) begin
              state_d = StIdle;
              pwm_d   = 1'b0;
            end
          end else begin
            cnt_d = cnt_inc;
            pwm_d = (cnt_inc < act_duty_q);
          end
        end
        // Only possible while nothing is pending, so it never collides with the
        // shadow-to-active transfer above; a wrap-cycle write waits one period.
        if (cfg_hs) begin
          shd_period_d = cfg_period;
          shd_duty_d   = cfg_duty;
          pending_d    = 1'b1;
        end
      end
      default: begin
        state_d = StIdle;
        cnt_d   = '0;
        pwm_d   = 1'b0;
      end
    endcase
  end

`ifdef PWM_COMPL_EN
  assign pwm_n_d = (state_d != StIdle) & ~pwm_d;
`endif

  always_ff @(posedge clk_in or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= StIdle;
      cnt_q        <= '0;
      act_period_q <= '0;
      act_duty_q   <= '0;
      shd_period_q <= '0;
      shd_duty_q   <= '0;
      pending_q    <= 1'b0;
      pwm_q        <= 1'b0;
      done_q       <= 1'b0;
`ifdef PWM_COMPL_EN
      pwm_n_q      <= 1'b0;
`endif
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      act_period_q <= act_period_d;
      act_duty_q   <= act_duty_d;
      shd_period_q <= shd_period_d;
      shd_duty_q   <= shd_duty_d;
      pending_q    <= pending_d;
      pwm_q        <= pwm_d;
      done_q       <= done_d;
`ifdef PWM_COMPL_EN
      pwm_n_q      <= pwm_n_d;
`endif
    end
  end

  assign cfg_ready   = ~pending_q;
  assign pwm_out     = pwm_q;
  assign period_done = done_q;
  assign busy        = (state_q != StIdle);
`ifdef PWM_COMPL_EN
  assign pwm_n       = pwm_n_q;
`endif

endmodule

// File: tb/tb_pwm_generator.sv
// Directed bench for pwm_generator: tick_src mimics a divide-by-4 clock
// (two cycles high, two low), so one tick arrives every four clk_in cycles.
module tb_pwm_generator;

  logic       clk_in = 1'b0;
  logic       rst_n;
  logic       tick_src;
  logic       enable;
  logic       cfg_valid;
  logic       cfg_ready;
  logic [7:0] cfg_period;
  logic [7:0] cfg_duty;
  logic       pwm_out;
  logic       period_done;
  logic       busy;
`ifdef PWM_COMPL_EN
  logic       pwm_n;
`endif

  int n_vec   = 0;
  int n_err   = 0;
  int tick_no = 0;
  int cyc     = 0;
  int last_done_cyc = 0;
  int done_gap      = 0;

  always #5 clk_in = ~clk_in;

  pwm_generator #(
    .WIDTH      (8),
    .SYNC_STAGES(2)
  ) dut (
    .clk_in     (clk_in),
    .rst_n      (rst_n),
    .tick_src   (tick_src),
    .enable     (enable),
    .cfg_valid  (cfg_valid),
    .cfg_ready  (cfg_ready),
    .cfg_period (cfg_period),
    .cfg_duty   (cfg_duty),
    .pwm_out    (pwm_out),
`ifdef PWM_COMPL_EN
    .pwm_n      (pwm_n),
`endif
    .period_done(period_done),
    .busy       (busy)
  );

  // Clock cycles between consecutive period_done pulses.
  always @(negedge clk_in) begin
    cyc = cyc + 1;
    if (period_done) begin
      done_gap      = cyc - last_done_cyc;
      last_done_cyc = cyc;
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout, required finish");
    $fatal(1);
  end

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec = n_vec + 1;
    if (got !== exp) begin
      n_err = n_err + 1;
      $display("FAIL %s (tick %0d): got %0h, expected %0h", tag, tick_no, got, exp);
    end
  endtask

  // One divider period: tick_src high for two samples, low for two. The tick
  // updates the DUT on the third edge; outputs are sampled just after it.
  task automatic tick_step(input bit do_cfg, input logic [7:0] per, input logic [7:0] duty,
                           input logic e_pwm, input logic e_done, input logic e_busy);
    @(negedge clk_in) tick_src = 1'b1;
    @(negedge clk_in);
    @(negedge clk_in) begin
      tick_src = 1'b0;
      if (do_cfg) begin
        cfg_valid  = 1'b1;
        cfg_period = per;
        cfg_duty   = duty;
      end
    end
    @(posedge clk_in);
    #1;
    cfg_valid = 1'b0;
    tick_no   = tick_no + 1;
    check_eq("pwm_out", {31'd0, pwm_out}, {31'd0, e_pwm});
    check_eq("period_done", {31'd0, period_done}, {31'd0, e_done});
    check_eq("busy", {31'd0, busy}, {31'd0, e_busy});
`ifdef PWM_COMPL_EN
    check_eq("pwm_n", {31'd0, pwm_n}, {31'd0, e_busy & ~e_pwm});
`endif
    @(posedge clk_in);
    #1;
    check_eq("done_1cyc", {31'd0, period_done}, 32'd0);
  endtask

  // Patterns are read left to right in time: bit n-1 is the first tick.
  task automatic ticks(input int n, input logic [15:0] pwm_pat, input logic [15:0] done_pat,
                       input logic e_busy);
    for (int i = 0; i < n; i++) begin
      tick_step(1'b0, 8'd0, 8'd0, pwm_pat[n-1-i], done_pat[n-1-i], e_busy);
    end
  endtask

  task automatic cfg_write(input logic [7:0] per, input logic [7:0] duty);
    @(negedge clk_in) begin
      cfg_valid  = 1'b1;
      cfg_period = per;
      cfg_duty   = duty;
    end
    @(posedge clk_in);
    #1 cfg_valid = 1'b0;
  endtask

  task automatic set_enable(input logic v);
    @(negedge clk_in) enable = v;
  endtask

  initial begin
    rst_n      = 1'b0;
    tick_src   = 1'b0;
    enable     = 1'b0;
    cfg_valid  = 1'b0;
    cfg_period = '0;
    cfg_duty   = '0;

    // Reset held while tick_src toggles.
    for (int i = 0; i < 4; i++) begin
      @(negedge clk_in) tick_src = ~tick_src;
      check_eq("rst_pwm", {31'd0, pwm_out}, 32'd0);
      check_eq("rst_done", {31'd0, period_done}, 32'd0);
      check_eq("rst_busy", {31'd0, busy}, 32'd0);
      check_eq("rst_ready", {31'd0, cfg_ready}, 32'd1);
    end
    @(negedge clk_in) begin
      tick_src = 1'b0;
      rst_n    = 1'b1;
    end
    repeat (3) @(negedge clk_in);

    // IDLE config 4/1: 1 high, 3 low per period.
    cfg_write(8'd4, 8'd1);
    check_eq("idle_ready", {31'd0, cfg_ready}, 32'd1);
    check_eq("idle_busy", {31'd0, busy}, 32'd0);
    set_enable(1'b1);
    ticks(9, 16'b100010001, 16'b000010001, 1'b1);
    check_eq("done_gap", done_gap, 32'd16);

    // Mid-period reconfigure to 5/3.
    ticks(1, 16'b0, 16'b0, 1'b1);
    cfg_write(8'd5, 8'd3);
    check_eq("pend_ready", {31'd0, cfg_ready}, 32'd0);
    ticks(2, 16'b00, 16'b00, 1'b1);
    check_eq("pend_ready2", {31'd0, cfg_ready}, 32'd0);
    ticks(1, 16'b1, 16'b1, 1'b1);
    check_eq("apply_ready", {31'd0, cfg_ready}, 32'd1);
    ticks(5, 16'b11001, 16'b00001, 1'b1);

    // Handshake on the wrap edge: old 5/3 runs one more period.
    ticks(4, 16'b1100, 16'b0000, 1'b1);
    tick_step(1'b1, 8'd4, 8'd2, 1'b1, 1'b1, 1'b1);
    check_eq("wrap_cfg_ready", {31'd0, cfg_ready}, 32'd0);
    ticks(5, 16'b11001, 16'b00001, 1'b1);
    check_eq("wrap_cfg_ready2", {31'd0, cfg_ready}, 32'd1);
    ticks(4, 16'b1001, 16'b0001, 1'b1);

    // enable drop at cnt=1: finish period, then IDLE.
    ticks(1, 16'b1, 16'b0, 1'b1);
    set_enable(1'b0);
    ticks(2, 16'b00, 16'b00, 1'b1);
    ticks(1, 16'b0, 16'b1, 1'b0);
    ticks(1, 16'b0, 16'b0, 1'b0);
    // Restart, then drop and re-assert within the period: no gap.
    set_enable(1'b1);
    ticks(2, 16'b11, 16'b00, 1'b1);
    set_enable(1'b0);
    ticks(1, 16'b0, 16'b0, 1'b1);
    set_enable(1'b1);
    ticks(3, 16'b011, 16'b010, 1'b1);

    // duty=0: never high.
    cfg_write(8'd4, 8'd0);
    check_eq("d0_ready", {31'd0, cfg_ready}, 32'd0);
    ticks(7, 16'b0000000, 16'b0010001, 1'b1);

    // duty=period=4: constant high.
    cfg_write(8'd4, 8'd4);
    ticks(8, 16'b00011111, 16'b00010001, 1'b1);

    // period=0: wraps on every tick.
    cfg_write(8'd0, 8'd1);
    ticks(7, 16'b1111111, 16'b0001111, 1'b1);

    // Stop with period 0: the very next tick wraps into IDLE.
    set_enable(1'b0);
    ticks(1, 16'b0, 16'b1, 1'b0);
    check_eq("end_ready", {31'd0, cfg_ready}, 32'd1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
